// File: rtl/enc_pkg.sv
// Shared definitions for the sequential 8-to-3 encoder, its decoder partner and the bench.
package enc_pkg;
  localparam int N_IN   = 8;
  localparam int CODE_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    STALL = 2'd2
  } state_e;

  // Sticky status flags, cleared only by reset
  typedef struct packed {
    logic multi;
    logic overflow;
  } flags_t;

  // One-hot line selected by a code; the inverse of the priority encoder
  function automatic logic [N_IN-1:0] onehot_of(input logic [CODE_W-1:0] code);
    logic [N_IN-1:0] oh;
    oh       = '0;
    oh[code] = 1'b1;
    return oh;
  endfunction
endpackage

// File: rtl/encoder_8to3_seq_if.sv
// Request/code handshake bundle between a producer/consumer and the encoder.
interface encoder_8to3_seq_if;
  import enc_pkg::*;

  logic              en;
  logic              req_valid;
  logic [N_IN-1:0]   req;
  logic              req_ready;
  logic              code_valid;
  logic              code_ready;
  logic [CODE_W-1:0] code;
  logic              multi;
  logic              overflow;
  logic              busy;

  modport master (
    output en, req_valid, req, code_ready,
    input  req_ready, code_valid, code, multi, overflow, busy
  );

  modport slave (
    input  en, req_valid, req, code_ready,
    output req_ready, code_valid, code, multi, overflow, busy
  );
endinterface

// File: rtl/decoder_3to8.sv
// 3-to-8 line decoder; regenerates the request line from an issued code.
module decoder_3to8
  import enc_pkg::*;
(
  input  logic              en,
  input  logic [CODE_W-1:0] code,
  output logic [N_IN-1:0]   y
);

  assign y = en ? onehot_of(code) : '0;

endmodule

// File: rtl/prio_enc8.sv
// Combinational highest-set-bit encoder.
module prio_enc8
  import enc_pkg::*;
(
  input  logic [N_IN-1:0]   req,
  output logic [CODE_W-1:0] idx,
  output logic              any
);

  // Ascending scan so the highest set bit is the last to write idx
  always_comb begin
    idx = '0;
    any = |req;
    for (int i = 0; i < N_IN; i++) begin
      if (req[i]) idx = CODE_W'(i);
    end
  end

endmodule

// File: rtl/encoder_8to3_seq.sv
// Sequential priority encoder: collects requests into a pending set and
// issues one code per cycle, highest index first, over a valid/ready slot.
module encoder_8to3_seq
  import enc_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  encoder_8to3_seq_if.slave  bus
);

  logic [N_IN-1:0]   pending_q, pending_d;
  logic [N_IN-1:0]   issue_mask;
  logic [CODE_W-1:0] code_q, code_d;
  logic              code_valid_q, code_valid_d;
  flags_t            flags_q, flags_d;
  state_e            state_q, state_d;

  logic [CODE_W-1:0] sel_idx;
  logic              sel_any;
  logic              accept;
  logic              slot_free;
  logic              load;

  // Selection looks only at the registered pending set: no same-cycle bypass
  prio_enc8 u_prio (
    .req (pending_q),
    .idx (sel_idx),
    .any (sel_any)
  );

  // Next pending set, output slot, sticky flags and state
  always_comb begin
    accept     = bus.req_valid && bus.en;
    slot_free  = !code_valid_q || bus.code_ready;
    load       = slot_free && bus.en && sel_any;
    issue_mask = load ? onehot_of(sel_idx) : '0;

    // Incoming req is OR'd after the clear, so a bit re-requested on its
    // own issue edge stays pending
    pending_d    = (pending_q & ~issue_mask) | (accept ? bus.req : '0);
    code_d       = load ? sel_idx : code_q;
    // A free slot with nothing loaded (empty or disabled) drops valid
    code_valid_d = slot_free ? load : code_valid_q;

    flags_d = flags_q;
    if (accept) begin
      if (|(bus.req & pending_q & ~issue_mask))         flags_d.overflow = 1'b1;
      if (|(bus.req & (bus.req - N_IN'(1))))             flags_d.multi    = 1'b1;
    end

    if (!code_valid_d && (pending_d == '0))              state_d = IDLE;
    else if (code_valid_q && !bus.code_ready)            state_d = STALL;
    else                                                 state_d = DRAIN;
  end

  // Registered state, cleared asynchronously so reset discards a drain at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q    <= '0;
      code_q       <= '0;
      code_valid_q <= 1'b0;
      flags_q      <= '0;
      state_q      <= IDLE;
    end else begin
      pending_q    <= pending_d;
      code_q       <= code_d;
      code_valid_q <= code_valid_d;
      flags_q      <= flags_d;
      state_q      <= state_d;
    end
  end

  assign bus.req_ready  = bus.en;
  assign bus.code       = code_q;
  assign bus.code_valid = code_valid_q;
  assign bus.multi      = flags_q.multi;
  assign bus.overflow   = flags_q.overflow;
  assign bus.busy       = (state_q != IDLE) || (|pending_q);

endmodule

// File: tb/tb_encoder_8to3_seq.sv
// Directed bench for encoder_8to3_seq with a behavioural reference model.
module tb_encoder_8to3_seq;
  import enc_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] dec_y;

  always #5 clk = ~clk;

  encoder_8to3_seq_if bus();

  encoder_8to3_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  decoder_3to8 u_dec (
    .en   (bus.code_valid),
    .code (bus.code),
    .y    (dec_y)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int issued[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_seq(input string nm, input int n, input int a0, input int a1, input int a2);
    int e[3];
    e[0] = a0; e[1] = a1; e[2] = a2;
    chk({nm, "_count"}, 32'(issued.size()), 32'(n));
    for (int i = 0; i < n && i < issued.size(); i++)
      chk($sformatf("%s_code%0d", nm, i), 32'(issued[i]), 32'(e[i]));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  bit [7:0] m_pend;
  int       m_code;
  bit       m_cv, m_multi, m_ovf;
  bit       m_take;
  bit [7:0] m_rest;

  function automatic int top_bit(input bit [7:0] p);
    for (int i = 7; i >= 0; i--) if (p[i]) return i;
    return -1;
  endfunction

  always_comb begin
    m_take = (!m_cv || bus.code_ready) && bus.en && (m_pend != 8'h0);
    m_rest = m_pend;
    if (m_take) m_rest = m_pend & ~(8'h01 << top_bit(m_pend));
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend  <= 8'h0;
      m_code  <= 0;
      m_cv    <= 1'b0;
      m_multi <= 1'b0;
      m_ovf   <= 1'b0;
    end else begin
      if (m_take) begin
        m_code <= top_bit(m_pend);
        m_cv   <= 1'b1;
      end else if (!m_cv || bus.code_ready) begin
        m_cv <= 1'b0;
      end
      m_pend <= m_rest | ((bus.req_valid && bus.en) ? bus.req : 8'h0);
      if (bus.req_valid && bus.en) begin
        if ((bus.req & m_rest) != 8'h0) m_ovf   <= 1'b1;
        if ($countones(bus.req) > 1)    m_multi <= 1'b1;
      end
    end
  end

  // Per-cycle compare against the model, plus a log of consumed codes
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("cmp_code_valid", 32'(bus.code_valid), 32'(m_cv));
        chk("cmp_req_ready",  32'(bus.req_ready),  32'(bus.en));
        chk("cmp_busy",       32'(bus.busy),       32'(m_cv || (m_pend != 8'h0)));
        chk("cmp_multi",      32'(bus.multi),      32'(m_multi));
        chk("cmp_overflow",   32'(bus.overflow),   32'(m_ovf));
        if (m_cv) begin
          chk("cmp_code",    32'(bus.code), 32'(m_code));
          chk("cmp_decoded", 32'(dec_y),    32'(onehot_of(3'(m_code))));
        end
        if (bus.code_valid && bus.code_ready) issued.push_back(int'(bus.code));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    rst_n          = 1'b0;
    bus.en         = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req        = 8'h0;
    bus.code_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_code_valid", 32'(bus.code_valid), 32'd0);
    chk("rst_code",       32'(bus.code),       32'd0);
    chk("rst_busy",       32'(bus.busy),       32'd0);
    chk("rst_multi",      32'(bus.multi),      32'd0);
    chk("rst_overflow",   32'(bus.overflow),   32'd0);
    rst_n = 1'b1;

    // Single request: code 2 after two edges, idle the cycle after
    bus.en = 1'b1; bus.code_ready = 1'b1;
    bus.req_valid = 1'b1; bus.req = 8'b0000_0100;
    step();
    bus.req_valid = 1'b0;
    step();
    chk("t1_code_valid", 32'(bus.code_valid), 32'd1);
    chk("t1_code",       32'(bus.code),       32'd2);
    chk("t1_decoded",    32'(dec_y),          32'h04);
    step();
    chk("t1_busy",       32'(bus.busy),       32'd0);
    chk("t1_overflow",   32'(bus.overflow),   32'd0);
    chk("t1_code_valid_after", 32'(bus.code_valid), 32'd0);

    // Multi-hot drains highest first
    issued.delete();
    bus.req_valid = 1'b1; bus.req = 8'b1010_0001;
    step();
    bus.req_valid = 1'b0;
    repeat (4) step();
    chk_seq("t2", 3, 7, 5, 0);
    chk("t2_code_valid", 32'(bus.code_valid), 32'd0);
    chk("t2_multi",      32'(bus.multi),      32'd1);

    // Stall holds code 1 and keeps bit 0 pending
    issued.delete();
    bus.code_ready = 1'b0;
    bus.req_valid = 1'b1; bus.req = 8'b0000_0011;
    step();
    bus.req_valid = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t3_hold_code%0d", i),  32'(bus.code),       32'd1);
      chk($sformatf("t3_hold_valid%0d", i), 32'(bus.code_valid), 32'd1);
      step();
    end
    bus.code_ready = 1'b1;
    repeat (2) step();
    chk_seq("t3", 2, 1, 0, 0);
    chk("t3_code_valid", 32'(bus.code_valid), 32'd0);

    // Same bit re-requested on its own issue edge: no overflow, two issues
    issued.delete();
    bus.req_valid = 1'b1; bus.req = 8'b0000_1000;
    step();
    step();
    bus.req_valid = 1'b0;
    repeat (2) step();
    chk_seq("t4a", 2, 3, 3, 0);
    chk("t4a_overflow", 32'(bus.overflow), 32'd0);

    // Bit 3 re-requested while pending and not issuing: overflow, single issue
    issued.delete();
    bus.code_ready = 1'b0;
    bus.req_valid = 1'b1; bus.req = 8'b1000_1000;
    step();
    bus.req_valid = 1'b0;
    step();
    bus.req_valid = 1'b1; bus.req = 8'b0000_1000;
    step();
    bus.req_valid = 1'b0;
    chk("t4b_overflow", 32'(bus.overflow), 32'd1);
    bus.code_ready = 1'b1;
    repeat (2) step();
    chk_seq("t4b", 2, 7, 3, 0);
    chk("t4b_code_valid", 32'(bus.code_valid), 32'd0);

    // Disable during drain: presented code 7 completes, pending retained
    issued.delete();
    bus.req_valid = 1'b1; bus.req = 8'b1100_0000;
    step();
    bus.req_valid = 1'b0;
    step();
    bus.en = 1'b0; bus.code_ready = 1'b0;
    bus.req_valid = 1'b1; bus.req = 8'b0000_0001;
    #1;
    chk("t5_req_ready", 32'(bus.req_ready), 32'd0);
    step();
    chk("t5_hold_code",  32'(bus.code),       32'd7);
    chk("t5_hold_valid", 32'(bus.code_valid), 32'd1);
    bus.code_ready = 1'b1;
    step();
    chk("t5_dropped",    32'(bus.code_valid), 32'd0);
    chk("t5_busy",       32'(bus.busy),       32'd1);
    step();
    chk("t5_still_off",  32'(bus.code_valid), 32'd0);
    bus.req_valid = 1'b0;
    bus.en = 1'b1;
    step();
    chk("t5_code6",      32'(bus.code),       32'd6);
    step();
    chk_seq("t5", 2, 7, 6, 0);
    chk("t5_busy_end",   32'(bus.busy),       32'd0);

    // Reset mid-drain discards everything immediately
    bus.req_valid = 1'b1; bus.req = 8'hFF;
    step();
    bus.req_valid = 1'b0;
    repeat (2) step();
    chk("t6_pre_code", 32'(bus.code), 32'd6);
    rst_n = 1'b0;
    #1;
    chk("t6_code_valid", 32'(bus.code_valid), 32'd0);
    chk("t6_code",       32'(bus.code),       32'd0);
    chk("t6_busy",       32'(bus.busy),       32'd0);
    chk("t6_multi",      32'(bus.multi),      32'd0);
    chk("t6_overflow",   32'(bus.overflow),   32'd0);
    step();
    issued.delete();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("t6_quiet_valid%0d", i), 32'(bus.code_valid), 32'd0);
      chk($sformatf("t6_quiet_busy%0d", i),  32'(bus.busy),       32'd0);
    end
    chk("t6_none_issued", 32'(issued.size()), 32'd0);
    bus.req_valid = 1'b1; bus.req = 8'b0000_0010;
    step();
    bus.req_valid = 1'b0;
    step();
    chk("t6_new_code",    32'(bus.code),  32'd1);
    chk("t6_new_decoded", 32'(dec_y),     32'h02);
    step();
    chk("t6_new_done",    32'(bus.code_valid), 32'd0);
    chk("t6_new_multi",   32'(bus.multi),      32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
